uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  Transmit half of the UART. Latches one parallel byte plus frame config.
//  Builds an 11-bit frame and shifts it out LSB-first on tx at the selected baud.
//  Contains the bit-time counter and bit counter that drive the shift register;
//  done retires the frame after the 11th bit time.
//  Sits between the TSI/processor output port and the serial pin.
// PARAMETERS
//  CLK_HZ   100_000_000  system clock frequency; bit-time counts = CLK_HZ/baud, rounded
//  CNT_W    19           width of bit-time counter (must hold CLK_HZ/300)
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      asynchronous, active-high
//  load      in   1      1-cycle strobe: start a frame with data_in (accepted only if tx_rdy)
//  data_in   in   8      byte to transmit
//  baud_sel  in   4      0..12 = 300,600,1200,2400,4800,9600,19200,38400,57600,115200,230400,460800,921600
//  eight     in   1      1 = 8 data bits, 0 = 7 data bits (data_in[7] ignored)
//  pen       in   1      parity enable
//  ohel      in   1      parity sense: 1 = odd, 0 = even
//  tx        out  1      serial output, idle high
//  tx_rdy    out  1      1 = idle, ready for load
// BEHAVIOUR
//  Reset:
//   - tx=1, tx_rdy=1, shift reg=11'h7FF, doit=0, counters=0, config regs=0.
//   - Reset mid-frame aborts the frame immediately; tx returns high asynchronously.
//  Bit time k:
//   - CLK_HZ/baud rounded, from baud_sel via case table.
//   - baud_sel 13..15 use the 921600 count (109 @100 MHz).
//   - 300 baud = 333333, 9600 = 10417, 115200 = 868.
//  Load:
//   - On clk with load=1 and tx_rdy=1, latch data_in, eight, pen, ohel and baud_sel (k frozen for the frame).
//   - Same edge: doit<=1.
//   - load while tx_rdy=0 is ignored; the frame in flight is unaffected.
//  Frame build:
//   - Cycle after load, the 11-bit shift reg is loaded (bit0 sent first); tx_rdy=0 from this cycle.
//   - 8 bit + parity: {1, par, d7..d0, 0}
//   - 8 bit, no parity: {1, 1, d7..d0, 0}
//   - 7 bit + parity: {1, 1, par, d6..d0, 0}
//   - 7 bit, no parity: {1, 1, 1, d6..d0, 0}
//   - par = ohel ? ~^data : ^data, over the 7 or 8 data bits in use.
//  Shifting:
//   - tx = shift_reg[0], registered.
//   - Bit-time counter runs only while doit=1; btu=1 when count==k-1, then the counter clears.
//   - On btu: shift right, filling 1; bit counter increments.
//   - First btu (start bit ends) occurs k cycles after shift-reg load.
//  Done:
//   - done=1 when bit count reaches 11.
//   - Clears doit and both counters; tx_rdy=1 the next cycle; tx stays 1.
//   - Back-to-back: a load on the first tx_rdy=1 cycle is accepted.
//   - Min frame period = 11*k + 2 clocks.
//  No overflow: bit counter never exceeds 11; bit-time counter never exceeds k-1.
// TESTING
//  - reset released, no load -> tx=1, tx_rdy=1 held 1000 cycles.
//  - baud_sel=12, eight=1, pen=0, load 8'hA5 -> tx bits 0,1,0,1,0,0,1,0,1,1,1, 109 cycles each; tx_rdy back high 11*109+2 cycles after load.
//  - eight=1, pen=1, ohel=0, data 8'h07 -> bit9 (parity)=1; with ohel=1 -> parity=0.
//  - eight=0, pen=1, ohel=1, data 8'hFF -> d6..d0=1111111, bit8 parity=0, bits 9,10=1; data_in[7] ignored.
//  - load 8'h55, then load 8'h00 mid-frame -> second load ignored, 8'h55 frame intact; load on first tx_rdy cycle -> 8'h00 starts.
//  - reset asserted at bit 5 of a frame -> tx=1 and tx_rdy=1 at once; next load sends a full clean frame.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: latches one byte plus frame config, builds an 11-bit frame
// and shifts it out LSB-first on tx at the selected baud rate.
module uart_tx_engine #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int          CNT_W  = 19
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data_in,
   input  logic [3:0] baud_sel,
   input  logic       eight,
   input  logic       pen,
   input  logic       ohel,
   output logic       tx,
   output logic       tx_rdy
);

   logic [7:0]       data_q, data_d;
   logic             eight_q, eight_d;
   logic             pen_q, pen_d;
   logic             ohel_q, ohel_d;
   logic [3:0]       sel_q, sel_d;
   logic             doit_q, doit_d;
   logic             ld_q, ld_d;
   logic [10:0]      shift_q, shift_d;
   logic [CNT_W-1:0] bt_cnt_q, bt_cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;

   logic             accept;
   logic             btu;
   logic             done;
   logic             par;
   logic [CNT_W-1:0] k;

   function automatic logic [CNT_W-1:0] div_round(input int unsigned baud);
      return CNT_W'((CLK_HZ + baud / 2) / baud);
   endfunction

   // Codes 13..15 fall back to the fastest rate.
   function automatic logic [CNT_W-1:0] bit_time(input logic [3:0] sel);
      case (sel)
         4'd0:    return div_round(300);
         4'd1:    return div_round(600);
         4'd2:    return div_round(1200);
         4'd3:    return div_round(2400);
         4'd4:    return div_round(4800);
         4'd5:    return div_round(9600);
         4'd6:    return div_round(19200);
         4'd7:    return div_round(38400);
         4'd8:    return div_round(57600);
         4'd9:    return div_round(115200);
         4'd10:   return div_round(230400);
         4'd11:   return div_round(460800);
         default: return div_round(921600);
      endcase
   endfunction

   // NOTE: every signal written here gets its default first, so no path can infer a latch.
   always_comb begin
      data_d    = data_q;
      eight_d   = eight_q;
      pen_d     = pen_q;
      ohel_d    = ohel_q;
      sel_d     = sel_q;
      doit_d    = doit_q;
      ld_d      = 1'b0;
      shift_d   = shift_q;
      bt_cnt_d  = bt_cnt_q;
      bit_cnt_d = bit_cnt_q;

      accept = load & ~doit_q;
      k      = bit_time(sel_q);
      btu    = doit_q & ~ld_q & (bt_cnt_q == k - CNT_W'(1));
      done   = (bit_cnt_q == 4'd11);
      par    = (eight_q ? ^data_q : ^data_q[6:0]) ^ ohel_q;

      if (accept) begin
         data_d  = data_in;
         eight_d = eight;
         pen_d   = pen;
         ohel_d  = ohel;
         sel_d   = baud_sel;
         doit_d  = 1'b1;
         ld_d    = 1'b1;
      end

      // Frame is assembled one cycle after the load, from the latched config.
      if (ld_q) begin
         case ({eight_q, pen_q})
            2'b11:   shift_d = {1'b1, par, data_q, 1'b0};
            2'b10:   shift_d = {1'b1, 1'b1, data_q, 1'b0};
            2'b01:   shift_d = {1'b1, 1'b1, par, data_q[6:0], 1'b0};
            default: shift_d = {1'b1, 1'b1, 1'b1, data_q[6:0], 1'b0};
         endcase
      end

      if (done) begin
         doit_d    = 1'b0;
         bt_cnt_d  = '0;
         bit_cnt_d = '0;
      end else if (doit_q && !ld_q) begin
         if (btu) begin
            bt_cnt_d  = '0;
            shift_d   = {1'b1, shift_q[10:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end else begin
            bt_cnt_d  = bt_cnt_q + CNT_W'(1);
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q    <= '0;
         eight_q   <= 1'b0;
         pen_q     <= 1'b0;
         ohel_q    <= 1'b0;
         sel_q     <= '0;
         doit_q    <= 1'b0;
         ld_q      <= 1'b0;
         shift_q   <= 11'h7FF;
         bt_cnt_q  <= '0;
         bit_cnt_q <= '0;
      end else begin
         data_q    <= data_d;
         eight_q   <= eight_d;
         pen_q     <= pen_d;
         ohel_q    <= ohel_d;
         sel_q     <= sel_d;
         doit_q    <= doit_d;
         ld_q      <= ld_d;
         shift_q   <= shift_d;
         bt_cnt_q  <= bt_cnt_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // tx comes straight from a flop, so reset drives the line high without waiting for clk.
   assign tx     = shift_q[0];
   assign tx_rdy = ~doit_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: per-cycle comparison of tx and tx_rdy
// against a frame model built from the data/parity rules and a literal bit-time table.
module tb_uart_tx_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [7:0] data_in;
   logic [3:0] baud_sel;
   logic       eight;
   logic       pen;
   logic       ohel;
   logic       tx;
   logic       tx_rdy;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0] d;
      logic       eight;
      logic       pen;
      logic       ohel;
      logic [3:0] sel;
   } frame_t;

   int k_tbl [13] = '{333333, 166667, 83333, 41667, 20833, 10417, 5208,
                      2604, 1736, 868, 434, 217, 109};

   always #5 clk = ~clk;

   uart_tx_engine dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .data_in  (data_in),
      .baud_sel (baud_sel),
      .eight    (eight),
      .pen      (pen),
      .ohel     (ohel),
      .tx       (tx),
      .tx_rdy   (tx_rdy)
   );

   function automatic int k_of(input logic [3:0] sel);
      return (sel > 4'd12) ? k_tbl[12] : k_tbl[sel];
   endfunction

   // Wire order: start bit, data LSB first, optional parity, then stop/fill ones.
   function automatic logic [10:0] model_bits(input frame_t f);
      bit          q[$];
      int          nbits;
      int          ones;
      logic [10:0] b;
      nbits = f.eight ? 8 : 7;
      ones  = 0;
      q.push_back(1'b0);
      for (int i = 0; i < nbits; i++) begin
         q.push_back(f.d[i]);
         ones += int'(f.d[i]);
      end
      if (f.pen) q.push_back(f.ohel ? (ones % 2 == 0) : (ones % 2 == 1));
      while (q.size() < 11) q.push_back(1'b1);
      for (int i = 0; i < 11; i++) b[i] = q[i];
      return b;
   endfunction

   function automatic frame_t mk(input logic [7:0] d, input logic e, input logic p,
                                 input logic o, input logic [3:0] s);
      frame_t f;
      f.d = d; f.eight = e; f.pen = p; f.ohel = o; f.sel = s;
      return f;
   endfunction

   task automatic drive_load(input frame_t f);
      load     = 1'b1;
      data_in  = f.d;
      eight    = f.eight;
      pen      = f.pen;
      ohel     = f.ohel;
      baud_sel = f.sel;
   endtask

   // Called just after a load was driven; checks every cycle up to the first tx_rdy=1 cycle.
   task automatic check_frame(input frame_t f, input string name, input int intrude_at,
                              input bit chain, input frame_t nxt);
      int          k;
      int          last;
      logic [10:0] b;
      logic        exp_tx;
      logic        exp_rdy;
      k    = k_of(f.sel);
      last = 11 * k + 2;
      b    = model_bits(f);
      for (int n = 0; n <= last; n++) begin
         @(negedge clk);
         exp_tx  = (n >= 1 && n <= 11 * k) ? b[(n - 1) / k] : 1'b1;
         exp_rdy = (n == last);
         checks++;
         if (tx !== exp_tx) begin
            failures++;
            $display("FAIL %s tx cycle=%0d got=%b exp=%b", name, n, tx, exp_tx);
         end
         checks++;
         if (tx_rdy !== exp_rdy) begin
            failures++;
            $display("FAIL %s tx_rdy cycle=%0d got=%b exp=%b", name, n, tx_rdy, exp_rdy);
         end
         load = 1'b0;
         if (n == intrude_at) drive_load(mk(8'h00, 1'b0, 1'b1, 1'b1, 4'd0));
         if (n == last && chain) drive_load(nxt);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1 || tx_rdy !== 1'b1) begin
         failures++;
         $display("FAIL reset_state got tx=%b rdy=%b exp tx=1 rdy=1", tx, tx_rdy);
      end
      reset = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1 || tx_rdy !== 1'b1) begin
            failures++;
            $display("FAIL idle cycle=%0d got tx=%b rdy=%b exp tx=1 rdy=1", i, tx, tx_rdy);
         end
      end
   endtask

   task automatic test_basic_a5;
      frame_t f;
      f = mk(8'hA5, 1'b1, 1'b0, 1'b0, 4'd12);
      drive_load(f);
      check_frame(f, "a5_8n", -1, 1'b0, f);
   endtask

   task automatic test_parity;
      frame_t f;
      f = mk(8'h07, 1'b1, 1'b1, 1'b0, 4'd12);
      drive_load(f);
      check_frame(f, "par_even", -1, 1'b0, f);
      f = mk(8'h07, 1'b1, 1'b1, 1'b1, 4'd12);
      drive_load(f);
      check_frame(f, "par_odd", -1, 1'b0, f);
   endtask

   task automatic test_seven_bit;
      frame_t f;
      f = mk(8'hFF, 1'b0, 1'b1, 1'b1, 4'd12);
      drive_load(f);
      check_frame(f, "seven_ff", -1, 1'b0, f);
      f = mk(8'h80, 1'b0, 1'b0, 1'b0, 4'd12);
      drive_load(f);
      check_frame(f, "seven_d7_ignored", -1, 1'b0, f);
   endtask

   task automatic test_back_to_back;
      frame_t f1;
      frame_t f2;
      f1 = mk(8'h55, 1'b1, 1'b0, 1'b0, 4'd12);
      f2 = mk(8'h00, 1'b1, 1'b0, 1'b0, 4'd12);
      drive_load(f1);
      check_frame(f1, "ignore_mid_load", 3 * 109 + 5, 1'b1, f2);
      check_frame(f2, "back_to_back", -1, 1'b0, f2);
   endtask

   task automatic test_baud_table;
      frame_t f;
      f = mk(8'h3C, 1'b1, 1'b1, 1'b0, 4'd9);
      drive_load(f);
      check_frame(f, "baud_115200", -1, 1'b0, f);
      f = mk(8'hC3, 1'b0, 1'b1, 1'b0, 4'd11);
      drive_load(f);
      check_frame(f, "baud_460800", -1, 1'b0, f);
      f = mk(8'h96, 1'b1, 1'b0, 1'b1, 4'd14);
      drive_load(f);
      check_frame(f, "baud_sel14", -1, 1'b0, f);
   endtask

   task automatic test_random;
      frame_t f;
      for (int i = 0; i < 5; i++) begin
         f = mk(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                4'($urandom_range(15, 10)));
         drive_load(f);
         check_frame(f, $sformatf("random%0d", i), -1, 1'b0, f);
      end
   endtask

   task automatic test_reset_mid_frame;
      frame_t f;
      int     k;
      f = mk(8'h0F, 1'b1, 1'b0, 1'b0, 4'd12);
      k = k_of(f.sel);
      drive_load(f);
      for (int n = 0; n <= 1 + 5 * k + 10; n++) begin
         @(negedge clk);
         load = 1'b0;
      end
      checks++;
      if (tx !== 1'b0 || tx_rdy !== 1'b0) begin
         failures++;
         $display("FAIL pre_reset_bit5 got tx=%b rdy=%b exp tx=0 rdy=0", tx, tx_rdy);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1 || tx_rdy !== 1'b1) begin
         failures++;
         $display("FAIL async_reset got tx=%b rdy=%b exp tx=1 rdy=1", tx, tx_rdy);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      f = mk(8'h5A, 1'b1, 1'b1, 1'b1, 4'd12);
      drive_load(f);
      check_frame(f, "after_reset", -1, 1'b0, f);
   endtask

   initial begin
      reset    = 1'b1;
      load     = 1'b0;
      data_in  = 8'h00;
      baud_sel = 4'd0;
      eight    = 1'b0;
      pen      = 1'b0;
      ohel     = 1'b0;
      test_reset;
      test_basic_a5;
      test_parity;
      test_seven_bit;
      test_back_to_back;
      test_baud_table;
      test_random;
      test_reset_mid_frame;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
